// File: rtl/halt_dump_unit.sv
`default_nettype none
// ============================================================================
//  Module      : halt_dump_unit
//  Description : Detects the CPU halt instruction, stalls the CPU and streams
//                all registers plus every non-zero data-memory word as
//                (kind, address, data) records over a valid/ready interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module halt_dump_unit #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] HALT_INSTR = 16'hE7FF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       instr,
    input  logic                        instr_valid,
    output logic                        cpu_stall,
    output logic [$clog2(NUM_REGS)-1:0] reg_rd_addr,
    input  logic [DATA_WIDTH-1:0]       reg_rd_data,
    output logic                        mem_rd_en,
    output logic [ADDR_WIDTH-1:0]       mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]       mem_rd_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_is_mem,
    output logic [ADDR_WIDTH-1:0]       out_addr,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        busy,
    output logic                        done
);

    localparam int                    REG_IDX_W   = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_REG  = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = {ADDR_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REG_EMIT = 3'd1,
        S_MEM_REQ  = 3'd2,
        S_MEM_WAIT = 3'd3,
        S_MEM_EMIT = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic [REG_IDX_W-1:0]    r_rd_idx;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic                    r_out_valid;
    logic                    r_out_is_mem;
    logic [ADDR_WIDTH-1:0]   r_out_addr;
    logic [DATA_WIDTH-1:0]   r_out_data;

    logic                    w_halt_seen;
    logic                    w_handshake;
    logic                    w_last_reg;
    logic                    w_last_addr;
    logic                    w_mem_nonzero;
    logic                    w_load_reg;
    logic                    w_load_mem;
    logic                    w_drop_valid;
    logic                    w_start_mem;
    logic                    w_adv_addr;

    assign w_halt_seen   = instr_valid && (instr == HALT_INSTR);
    assign w_handshake   = r_out_valid && out_ready;
    assign w_last_reg    = (r_out_addr == c_LAST_REG);
    assign w_last_addr   = (r_mem_addr == c_LAST_ADDR);
    assign w_mem_nonzero = |mem_rd_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load_reg   = 1'b0;
        w_load_mem   = 1'b0;
        w_drop_valid = 1'b0;
        w_start_mem  = 1'b0;
        w_adv_addr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_halt_seen) begin
                    w_next_state = S_REG_EMIT;
                end
            end
            S_REG_EMIT: begin
                // First cycle loads register 0; afterwards each accepted
                // record is immediately replaced by the next index.
                if (!r_out_valid) begin
                    w_load_reg = 1'b1;
                end else if (w_handshake) begin
                    if (w_last_reg) begin
                        w_drop_valid = 1'b1;
                        w_start_mem  = 1'b1;
                        w_next_state = S_MEM_REQ;
                    end else begin
                        w_load_reg = 1'b1;
                    end
                end
            end
            S_MEM_REQ: begin
                w_next_state = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (w_mem_nonzero) begin
                    w_load_mem   = 1'b1;
                    w_next_state = S_MEM_EMIT;
                end else if (w_last_addr) begin
                    w_next_state = S_DONE;
                end else begin
                    w_adv_addr   = 1'b1;
                    w_next_state = S_MEM_REQ;
                end
            end
            S_MEM_EMIT: begin
                if (w_handshake) begin
                    w_drop_valid = 1'b1;
                    if (w_last_addr) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_adv_addr   = 1'b1;
                        w_next_state = S_MEM_REQ;
                    end
                end
            end
            S_DONE: begin
                w_next_state = S_DONE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_idx     <= '0;
            r_mem_addr   <= '0;
            r_out_valid  <= 1'b0;
            r_out_is_mem <= 1'b0;
            r_out_addr   <= '0;
            r_out_data   <= '0;
        end else begin
            if (r_state == S_IDLE && w_halt_seen) begin
                r_rd_idx <= '0;
            end else if (w_load_reg) begin
                r_rd_idx <= r_rd_idx + REG_IDX_W'(1);
            end

            if (w_start_mem) begin
                r_mem_addr <= '0;
            end else if (w_adv_addr) begin
                r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
            end

            if (w_load_reg) begin
                r_out_valid  <= 1'b1;
                r_out_is_mem <= 1'b0;
                r_out_addr   <= ADDR_WIDTH'(r_rd_idx);
                r_out_data   <= reg_rd_data;
            end else if (w_load_mem) begin
                r_out_valid  <= 1'b1;
                r_out_is_mem <= 1'b1;
                r_out_addr   <= r_mem_addr;
                r_out_data   <= mem_rd_data;
            end else if (w_drop_valid) begin
                r_out_valid  <= 1'b0;
            end
        end
    end

    always_comb begin
        cpu_stall   = (r_state != S_IDLE);
        busy        = (r_state != S_IDLE) && (r_state != S_DONE);
        done        = (r_state == S_DONE);
        mem_rd_en   = (r_state == S_MEM_REQ);
        mem_rd_addr = r_mem_addr;
        reg_rd_addr = r_rd_idx;
        out_valid   = r_out_valid;
        out_is_mem  = r_out_is_mem;
        out_addr    = r_out_addr;
        out_data    = r_out_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_halt_dump_unit.sv
`default_nettype none
// Randomized bench for halt_dump_unit: expected record stream is computed
// directly from register/memory contents and compared at each handshake.
`timescale 1ns/1ps
module tb_halt_dump_unit;

    localparam int          AW    = 8;
    localparam int          DW    = 16;
    localparam int          NR    = 16;
    localparam int          RW    = $clog2(NR);
    localparam int          DEPTH = 1 << AW;
    localparam logic [15:0] HALT  = 16'hE7FF;

    typedef struct packed {
        logic          is_mem;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          cpu_stall;
    logic [RW-1:0] reg_rd_addr;
    logic [DW-1:0] reg_rd_data;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          out_valid;
    logic          out_ready;
    logic          out_is_mem;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;

    halt_dump_unit #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .HALT_INSTR (HALT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .cpu_stall   (cpu_stall),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_is_mem  (out_is_mem),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] regs [NR];
    logic [DW-1:0] mem  [DEPTH];

    assign reg_rd_data = regs[reg_rd_addr];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    int   n_checks = 0;
    int   n_errors = 0;
    rec_t exp_q[$];
    rec_t cur_rec;
    rec_t exp_rec;
    rec_t hold_rec;
    logic hold_prev = 1'b0;
    logic mon_en = 1'b0;
    int   rd_next = 0;
    logic rand_ready = 1'b0;
    logic hold_en = 1'b0;
    int   hold_reg = 0;
    int   hold_mem = 0;
    int   cyc;
    logic found;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: record order/content, stability under backpressure, read sweep order.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            cur_rec = {out_is_mem, out_addr, out_data};
            if (hold_prev) begin
                check_eq("hold_valid", 64'(out_valid), 64'd1);
                check_eq("hold_record", 64'(cur_rec), 64'(hold_rec));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_record", 64'(cur_rec), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_rec = exp_q.pop_front();
                    check_eq("record", 64'(cur_rec), 64'(exp_rec));
                end
            end
            hold_prev = out_valid && !out_ready;
            hold_rec  = cur_rec;
            if (mem_rd_en) begin
                check_eq("mem_rd_addr", 64'(mem_rd_addr), 64'(rd_next));
                rd_next++;
            end
        end
    end

    task automatic start_run();
        exp_q.delete();
        for (int i = 0; i < NR; i++) exp_q.push_back({1'b0, AW'(i), regs[i]});
        for (int a = 0; a < DEPTH; a++)
            if (mem[a] != '0) exp_q.push_back({1'b1, AW'(a), mem[a]});
        rd_next   = 0;
        hold_prev = 1'b0;
        hold_reg  = 0;
        hold_mem  = 0;
        mon_en    = 1'b1;
    endtask

    task automatic drive_ready();
        if (hold_en && out_valid && !out_is_mem && out_addr == AW'(3) && hold_reg < 5) begin
            out_ready = 1'b0;
            hold_reg++;
        end else if (hold_en && out_valid && out_is_mem && out_addr == AW'(5) && hold_mem < 5) begin
            out_ready = 1'b0;
            hold_mem++;
        end else if (rand_ready) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
        end
    endtask

    task automatic do_halt();
        instr       = HALT;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = DW'($urandom);
    endtask

    task automatic run_to_done(input int max_cyc, output int cycles);
        cycles = 0;
        while (!done && cycles < max_cyc) begin
            drive_ready();
            @(posedge clk);
            #1;
            cycles++;
        end
        check_eq("done_reached", 64'(done), 64'd1);
    endtask

    task automatic end_checks(input string tag);
        check_eq({tag, "_remaining"}, 64'(exp_q.size()), 64'd0);
        check_eq({tag, "_reads"}, 64'(rd_next), 64'(DEPTH));
        check_eq({tag, "_ctl"}, 64'({out_valid, busy, cpu_stall, mem_rd_en, done}), 64'b00101);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_ctl"}, 64'({cpu_stall, busy, done, mem_rd_en, out_valid, out_is_mem}), 64'd0);
        check_eq({tag, "_addr"}, 64'({reg_rd_addr, mem_rd_addr, out_addr}), 64'd0);
        check_eq({tag, "_data"}, 64'(out_data), 64'd0);
    endtask

    initial begin
        reset       = 1'b1;
        instr       = '0;
        instr_valid = 1'b0;
        out_ready   = 1'b0;
        for (int i = 0; i < NR; i++) regs[i] = '0;
        for (int a = 0; a < DEPTH; a++) mem[a] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        reset = 1'b0;

        // Halt encoding without valid, and a near-miss encoding with valid.
        instr = HALT; instr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("halt_novalid", 64'({cpu_stall, busy}), 64'd0);
        instr = 16'hE7FE; instr_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("near_halt", 64'({cpu_stall, busy}), 64'd0);
        instr_valid = 1'b0;

        // Run 1: regs = 3*i, sparse memory, forced stalls on reg 3 and mem 5.
        for (int i = 0; i < NR; i++) regs[i] = DW'(3 * i);
        mem[5]       = 16'd7;
        mem[DEPTH-1] = 16'hBEEF;
        start_run();
        hold_en = 1'b1; rand_ready = 1'b0; out_ready = 1'b1;
        do_halt();
        check_eq("halt_stall", 64'({cpu_stall, busy, done}), 64'b110);
        run_to_done(3000, cyc);
        end_checks("run1");

        // Done is sticky and further halts are ignored.
        for (int k = 0; k < 100; k++) begin
            instr = HALT; instr_valid = $urandom_range(0, 1);
            @(posedge clk);
            #1;
            check_eq("done_sticky", 64'({done, cpu_stall, busy, out_valid, mem_rd_en}), 64'b11000);
        end
        instr_valid = 1'b0;
        hold_en = 1'b0;

        // Run 2: random contents, random backpressure, reset at address 100.
        for (int i = 0; i < NR; i++) regs[i] = DW'($urandom);
        for (int a = 0; a < DEPTH; a++) mem[a] = ($urandom_range(0, 7) == 0) ? DW'($urandom_range(1, 65535)) : '0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start_run();
        rand_ready = 1'b1;
        do_halt();
        cyc = 0;
        found = 1'b0;
        while (!found && cyc < 5000) begin
            drive_ready();
            @(posedge clk);
            #1;
            cyc++;
            found = mem_rd_en && (mem_rd_addr == AW'(100));
        end
        check_eq("reach_addr100", 64'(found), 64'd1);
        #2;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check_zero_outputs("midreset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Run 3: restart after abort; must begin again at register 0.
        start_run();
        do_halt();
        drive_ready();
        @(posedge clk);
        #1;
        check_eq("restart_first", 64'({out_valid, out_is_mem, out_addr, out_data}),
                 64'({1'b1, 1'b0, AW'(0), regs[0]}));
        run_to_done(6000, cyc);
        end_checks("run3");

        // Run 4: everything zero, full-rate sink, exact sweep latency.
        for (int i = 0; i < NR; i++) regs[i] = '0;
        for (int a = 0; a < DEPTH; a++) mem[a] = '0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        start_run();
        do_halt();
        run_to_done(3000, cyc);
        end_checks("run4");
        check_eq("zero_latency", 64'(cyc), 64'(NR + 2 * DEPTH + 1));

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
